// File: rtl/ifu_pkg.sv
// Shared types and constants for the prefetching instruction fetch unit.
//   fetch_state_e : fetch FSM states (REQ / WAIT / DROP / HALT)
//   fetch_entry_t : one queued instruction {pc, inst, err} at default widths
//   INST_BYTES    : PC step for the default instruction width
//   RESET_PC_DEFAULT : fetch PC after reset (MBASE)
package ifu_pkg;

  localparam int unsigned IFU_ADDR_WIDTH = 32;
  localparam int unsigned IFU_DATA_WIDTH = 32;
  localparam int unsigned INST_BYTES     = IFU_DATA_WIDTH / 8;

  localparam logic [IFU_ADDR_WIDTH-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef enum logic [1:0] {
    REQ  = 2'd0,  // may issue a request when credit allows
    WAIT = 2'd1,  // one request outstanding, response will be queued
    DROP = 2'd2,  // one stale request outstanding, response will be discarded
    HALT = 2'd3   // fault delivered; idle until redirect
  } fetch_state_e;

  typedef struct packed {
    logic [IFU_ADDR_WIDTH-1:0] pc;
    logic [IFU_DATA_WIDTH-1:0] inst;
    logic                      err;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_inst_fifo.sv
// Synchronous instruction queue.
//   clk, rst       : clock, asynchronous active-low reset
//   push/push_data : write an entry (ignored when full unless popping too)
//   pop            : drop the head entry (ignored when empty)
//   flush          : empty the queue; overrides push and pop
//   head           : current head entry (undefined content when empty)
//   count/empty/full : occupancy
module ifu_inst_fifo
  import ifu_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  input  logic                     flush,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_V = (PW+1)'(DEPTH);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [PW:0]     cnt;
  logic            do_push;
  logic            do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == DEPTH_V);
  assign do_pop  = pop && !empty;
  // A push into a full queue is legal when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign count   = cnt;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed behind the count.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Prefetching instruction fetch unit.
//   clk, rst          : clock, asynchronous active-low reset
//   redirect_valid/pc : restart the fetch stream at a new PC (highest priority)
//   mem_req_*         : request channel to instruction memory (one outstanding)
//   mem_resp_*        : response channel, one cycle of valid per accepted request
//   out_*             : queue head towards the decoder
//   dbg_state         : current fetch FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. While valid is high and ready low, the producer holds valid and
// payload stable; the only exception is mem_req_* in a redirect cycle, which
// may be withdrawn or readdressed. mem_resp_valid has no ready: every response
// is consumed the cycle it arrives, which the credit rule makes safe.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = IFU_ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH = IFU_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT),
  parameter int unsigned           DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  input  logic                  mem_resp_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_inst,
  output logic                  out_err,
  output fetch_state_e          dbg_state
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] inst;
    logic                  err;
  } entry_t;

  localparam int unsigned           STEP       = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] STEP_V     = ADDR_WIDTH'(STEP);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STEP - 1);
  localparam int unsigned           CW         = $clog2(DEPTH) + 1;
  localparam logic [CW:0]           DEPTH_V    = (CW+1)'(DEPTH);

  fetch_state_e          state;
  fetch_state_e          state_nxt;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] req_pc;
  // Set by a misaligned redirect; the fault entry is queued once any stale
  // response has drained and the FSM is back in REQ.
  logic                  misalign_pend;

  logic                  in_flight;
  logic [CW:0]           occupancy;
  logic                  credit;
  logic                  req_fire;
  logic                  misalign_push;
  logic                  push_valid;
  entry_t                push_entry;
  entry_t                q_head;
  logic [CW-1:0]         q_count;
  logic                  q_empty;
  logic                  q_full;

  assign in_flight     = (state == WAIT) || (state == DROP);
  assign occupancy     = {1'b0, q_count} + {{CW{1'b0}}, in_flight};
  assign credit        = !q_full && (occupancy < DEPTH_V);
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign misalign_push = (state == REQ) && misalign_pend && credit;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= REQ;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      REQ: begin
        if (misalign_push)  state_nxt = HALT;
        else if (req_fire)  state_nxt = WAIT;
      end
      WAIT: begin
        if (mem_resp_valid) state_nxt = mem_resp_err ? HALT : REQ;
      end
      DROP: begin
        if (mem_resp_valid) state_nxt = REQ;
      end
      HALT: state_nxt = HALT;
    endcase
    // A response landing in the redirect cycle retires the only outstanding
    // request, so DROP is needed only if something is still owed afterwards.
    if (redirect_valid) begin
      state_nxt = (req_fire || (in_flight && !mem_resp_valid)) ? DROP : REQ;
    end
  end

  // Output logic
  always_comb begin
    mem_req_valid = rst && (state == REQ) && !misalign_pend && credit;
    mem_req_addr  = fetch_pc;
    push_valid    = 1'b0;
    push_entry    = '{pc: req_pc, inst: mem_resp_data, err: mem_resp_err};
    if (!redirect_valid) begin
      if (state == WAIT && mem_resp_valid) begin
        push_valid = 1'b1;
      end else if (misalign_push) begin
        push_valid = 1'b1;
        push_entry = '{pc: fetch_pc, inst: '0, err: 1'b1};
      end
    end
  end

  // Fetch PC / request PC datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc      <= RESET_PC;
      req_pc        <= RESET_PC;
      misalign_pend <= 1'b0;
    end else begin
      if (req_fire) req_pc <= fetch_pc;
      if (redirect_valid) begin
        fetch_pc      <= redirect_pc;
        misalign_pend <= |(redirect_pc & ALIGN_MASK);
      end else begin
        if (req_fire)      fetch_pc      <= fetch_pc + STEP_V;
        if (misalign_push) misalign_pend <= 1'b0;
      end
    end
  end

  ifu_inst_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_valid),
    .push_data (push_entry),
    .pop       (out_ready),
    .flush     (redirect_valid),
    .head      (q_head),
    .count     (q_count),
    .empty     (q_empty),
    .full      (q_full)
  );

  // Head fields are masked when empty so the decoder never sees stale storage.
  assign out_valid = !q_empty;
  assign out_pc    = out_valid ? q_head.pc   : '0;
  assign out_inst  = out_valid ? q_head.inst : '0;
  assign out_err   = out_valid && q_head.err;
  assign dbg_state = state;

endmodule

// File: tb/tb_ifu_prefetch.sv
module tb_ifu_prefetch;
  import ifu_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } ent_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         redirect_valid = 1'b0;
  logic [31:0]  redirect_pc    = '0;
  logic         mem_req_valid;
  logic         mem_req_ready  = 1'b0;
  logic [31:0]  mem_req_addr;
  logic         mem_resp_valid;
  logic [31:0]  mem_resp_data;
  logic         mem_resp_err;
  logic         out_valid;
  logic         out_ready      = 1'b0;
  logic [31:0]  out_pc;
  logic [31:0]  out_inst;
  logic         out_err;
  fetch_state_e dbg_state;

  ifu_prefetch #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .RESET_PC   (32'h8000_0000),
    .DEPTH      (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .mem_resp_err   (mem_resp_err),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_err        (out_err),
    .dbg_state      (dbg_state)
  );

  int passed = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic [31:0] req_log[$];
  ent_t        out_log[$];

  // Instruction memory contents
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h1234, ~a[15:0]};
  endfunction

  // ---------------- memory model ----------------
  int          resp_delay = 0;
  logic        err_en     = 1'b0;
  logic [31:0] err_addr   = '0;
  logic        pend;
  logic [31:0] pend_addr;
  int          dly_cnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend           <= 1'b0;
      pend_addr      <= '0;
      dly_cnt        <= 0;
      mem_resp_valid <= 1'b0;
      mem_resp_data  <= '0;
      mem_resp_err   <= 1'b0;
    end else begin
      mem_resp_valid <= 1'b0;
      mem_resp_err   <= 1'b0;
      if (pend) begin
        if (dly_cnt == 0) begin
          mem_resp_valid <= 1'b1;
          mem_resp_data  <= mem_word(pend_addr);
          mem_resp_err   <= err_en && (pend_addr == err_addr);
          pend           <= 1'b0;
        end else begin
          dly_cnt <= dly_cnt - 1;
        end
      end
      if (mem_req_valid && mem_req_ready) begin
        if (resp_delay == 0) begin
          mem_resp_valid <= 1'b1;
          mem_resp_data  <= mem_word(mem_req_addr);
          mem_resp_err   <= err_en && (mem_req_addr == err_addr);
        end else begin
          pend      <= 1'b1;
          pend_addr <= mem_req_addr;
          dly_cnt   <= resp_delay - 1;
        end
      end
    end
  end

  // ---------------- monitors ----------------
  ent_t mon_e;
  always @(posedge clk) begin
    if (rst) begin
      if (mem_req_valid && mem_req_ready) req_log.push_back(mem_req_addr);
      if (out_valid && out_ready) begin
        mon_e.pc   = out_pc;
        mon_e.inst = out_inst;
        mon_e.err  = out_err;
        out_log.push_back(mon_e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst            = 1'b0;
    mem_req_ready  = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    resp_delay     = 0;
    err_en         = 1'b0;
    repeat (2) @(negedge clk);
    req_log.delete();
    out_log.delete();
    rst = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (mem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %0b want 0", mem_req_valid); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", out_valid); else passed++;
    checks++; if (dbg_state !== REQ) $display("FAIL reset_state: got %0d want %0d", dbg_state, REQ); else passed++;
    @(negedge clk);
    req_log.delete();
    out_log.delete();
    rst = 1'b1;
    #1;
    checks++; if (mem_req_valid !== 1'b1) $display("FAIL reset_release_req_valid: got %0b want 1", mem_req_valid); else passed++;
    checks++; if (mem_req_addr !== 32'h8000_0000) $display("FAIL reset_release_addr: got %h want 80000000", mem_req_addr); else passed++;
  endtask

  task automatic test_stream();
    do_reset();
    mem_req_ready = 1'b1;
    out_ready     = 1'b1;
    for (int i = 0; i < 60 && out_log.size() < 3; i++) @(negedge clk);
    checks++; if (out_log.size() < 3) $display("FAIL stream_timeout: got %0d entries want 3", out_log.size()); else passed++;
    exp_q = {32'h8000_0000, 32'h8000_0004, 32'h8000_0008};
    for (int i = 0; i < 3; i++) begin
      checks++; if (req_log[i] !== exp_q[i]) $display("FAIL stream_req_addr[%0d]: got %h want %h", i, req_log[i], exp_q[i]); else passed++;
      checks++; if (out_log[i].pc !== exp_q[i]) $display("FAIL stream_out_pc[%0d]: got %h want %h", i, out_log[i].pc, exp_q[i]); else passed++;
      checks++; if (out_log[i].inst !== mem_word(exp_q[i])) $display("FAIL stream_out_inst[%0d]: got %h want %h", i, out_log[i].inst, mem_word(exp_q[i])); else passed++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mem_req_ready = 1'b1;
    out_ready     = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (req_log.size() != 4) $display("FAIL bp_req_count: got %0d want 4", req_log.size()); else passed++;
    checks++; if (mem_req_valid !== 1'b0) $display("FAIL bp_req_valid: got %0b want 0", mem_req_valid); else passed++;
    checks++; if (out_pc !== 32'h8000_0000) $display("FAIL bp_head_pc: got %h want 80000000", out_pc); else passed++;
    out_ready = 1'b1;
    for (int i = 0; i < 80 && out_log.size() < 8; i++) @(negedge clk);
    checks++; if (req_log[4] !== 32'h8000_0010) $display("FAIL bp_resume_addr: got %h want 80000010", req_log[4]); else passed++;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h8000_0000 + 32'(4 * i));
    for (int i = 0; i < 8; i++) begin
      checks++; if (out_log[i].pc !== exp_q[i]) $display("FAIL bp_out_pc[%0d]: got %h want %h", i, out_log[i].pc, exp_q[i]); else passed++;
    end
  endtask

  task automatic test_redirect_wait();
    logic found;
    do_reset();
    resp_delay    = 3;
    mem_req_ready = 1'b1;
    out_ready     = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      found = (dbg_state == WAIT) && (req_log.size() == 3);
    end
    checks++; if (!found) $display("FAIL rdw_reach_wait: got 0 want 1"); else passed++;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (dbg_state !== DROP) $display("FAIL rdw_state_drop: got %0d want %0d", dbg_state, DROP); else passed++;
    for (int i = 0; i < 100 && out_log.size() < 3; i++) @(negedge clk);
    checks++; if (out_log[1].pc !== 32'h8000_0004) $display("FAIL rdw_prev_pc: got %h want 80000004", out_log[1].pc); else passed++;
    checks++; if (out_log[2].pc !== 32'h8000_0100) $display("FAIL rdw_first_pc: got %h want 80000100", out_log[2].pc); else passed++;
    checks++; if (out_log[2].inst !== mem_word(32'h8000_0100)) $display("FAIL rdw_first_inst: got %h want %h", out_log[2].inst, mem_word(32'h8000_0100)); else passed++;
    checks++; if (req_log[3] !== 32'h8000_0100) $display("FAIL rdw_next_req: got %h want 80000100", req_log[3]); else passed++;
  endtask

  task automatic test_redirect_handshake();
    logic found;
    int   n;
    do_reset();
    mem_req_ready = 1'b1;
    out_ready     = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      found = (dbg_state == REQ) && mem_req_valid && out_valid;
    end
    checks++; if (!found) $display("FAIL rdh_setup: got 0 want 1"); else passed++;
    n = req_log.size();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0300;
    out_ready      = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    out_log.delete();
    checks++; if (out_valid !== 1'b0) $display("FAIL rdh_flushed: got %0b want 0", out_valid); else passed++;
    checks++; if (dbg_state !== DROP) $display("FAIL rdh_state_drop: got %0d want %0d", dbg_state, DROP); else passed++;
    for (int i = 0; i < 50 && out_log.size() < 1; i++) @(negedge clk);
    checks++; if (out_log[0].pc !== 32'h8000_0300) $display("FAIL rdh_first_pc: got %h want 80000300", out_log[0].pc); else passed++;
    checks++; if (req_log[n] !== 32'h8000_0004) $display("FAIL rdh_stale_req: got %h want 80000004", req_log[n]); else passed++;
    checks++; if (req_log[n+1] !== 32'h8000_0300) $display("FAIL rdh_restart_req: got %h want 80000300", req_log[n+1]); else passed++;
  endtask

  task automatic test_misaligned();
    do_reset();
    mem_req_ready  = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (dbg_state !== DROP) $display("FAIL mis_state_drop: got %0d want %0d", dbg_state, DROP); else passed++;
    repeat (5) @(negedge clk);
    checks++; if (out_valid !== 1'b1) $display("FAIL mis_out_valid: got %0b want 1", out_valid); else passed++;
    checks++; if (out_pc !== 32'h8000_0102) $display("FAIL mis_out_pc: got %h want 80000102", out_pc); else passed++;
    checks++; if (out_err !== 1'b1) $display("FAIL mis_out_err: got %0b want 1", out_err); else passed++;
    checks++; if (out_inst !== 32'h0) $display("FAIL mis_out_inst: got %h want 0", out_inst); else passed++;
    checks++; if (dbg_state !== HALT) $display("FAIL mis_state_halt: got %0d want %0d", dbg_state, HALT); else passed++;
    checks++; if (req_log.size() != 1) $display("FAIL mis_no_request: got %0d want 1", req_log.size()); else passed++;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (mem_req_valid !== 1'b0) $display("FAIL mis_halt_req_valid: got %0b want 0", mem_req_valid); else passed++;
    checks++; if (req_log.size() != 1) $display("FAIL mis_halt_no_req: got %0d want 1", req_log.size()); else passed++;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int i = 0; i < 50 && out_log.size() < 2; i++) @(negedge clk);
    checks++; if (out_log[0].err !== 1'b1) $display("FAIL mis_popped_err: got %0b want 1", out_log[0].err); else passed++;
    checks++; if (out_log[1].pc !== 32'h8000_0200) $display("FAIL mis_resume_pc: got %h want 80000200", out_log[1].pc); else passed++;
    checks++; if (req_log[1] !== 32'h8000_0200) $display("FAIL mis_resume_req: got %h want 80000200", req_log[1]); else passed++;
  endtask

  task automatic test_resp_err();
    do_reset();
    err_addr      = 32'h8000_0004;
    err_en        = 1'b1;
    mem_req_ready = 1'b1;
    out_ready     = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (out_log.size() != 2) $display("FAIL err_out_count: got %0d want 2", out_log.size()); else passed++;
    checks++; if (out_log[0].pc !== 32'h8000_0000 || out_log[0].err !== 1'b0) $display("FAIL err_first: got %h/%0b want 80000000/0", out_log[0].pc, out_log[0].err); else passed++;
    checks++; if (out_log[1].pc !== 32'h8000_0004 || out_log[1].err !== 1'b1) $display("FAIL err_second: got %h/%0b want 80000004/1", out_log[1].pc, out_log[1].err); else passed++;
    checks++; if (req_log.size() != 2) $display("FAIL err_req_count: got %0d want 2", req_log.size()); else passed++;
    checks++; if (dbg_state !== HALT) $display("FAIL err_state_halt: got %0d want %0d", dbg_state, HALT); else passed++;
    err_en = 1'b0;
  endtask

  task automatic test_async_reset();
    logic found;
    do_reset();
    resp_delay    = 3;
    mem_req_ready = 1'b1;
    out_ready     = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      found = (dbg_state == WAIT) && (req_log.size() == 2);
    end
    checks++; if (!found || out_valid !== 1'b1) $display("FAIL ar_setup: got %0b/%0b want 1/1", found, out_valid); else passed++;
    #2;
    rst = 1'b0;
    #1;
    checks++; if (mem_req_valid !== 1'b0) $display("FAIL ar_req_valid: got %0b want 0", mem_req_valid); else passed++;
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_inst !== 32'h0 || out_err !== 1'b0) $display("FAIL ar_out_zero: got %0b/%h/%h/%0b want 0/0/0/0", out_valid, out_pc, out_inst, out_err); else passed++;
    checks++; if (dbg_state !== REQ) $display("FAIL ar_state: got %0d want %0d", dbg_state, REQ); else passed++;
    @(negedge clk);
    req_log.delete();
    out_log.delete();
    rst       = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && out_log.size() < 1; i++) @(negedge clk);
    checks++; if (req_log[0] !== 32'h8000_0000) $display("FAIL ar_restart_req: got %h want 80000000", req_log[0]); else passed++;
    checks++; if (out_log[0].pc !== 32'h8000_0000) $display("FAIL ar_restart_pc: got %h want 80000000", out_log[0].pc); else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_handshake();
    test_misaligned();
    test_resp_err();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
